// File: rtl/apb_reg_access_seq_pkg.sv
// Shared types for the APB register-access sequencer: FSM state, per-entry
// operation, error-counter width and a saturating add helper.
package apb_reg_access_seq_pkg;

    localparam int ERR_CNT_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_ACCESS = 3'd2,
        ST_CHECK  = 3'd3,
        ST_DONE   = 3'd4
    } state_e;

    // Operation order applied to every table entry: WR0 -> RD -> WR1.
    typedef enum logic [1:0] {
        OP_WR0 = 2'd0,
        OP_RD  = 2'd1,
        OP_WR1 = 2'd2
    } op_e;

    // Add 0..3 to the error counter, sticking at all-ones.
    function automatic logic [ERR_CNT_W-1:0] sat_add(input logic [ERR_CNT_W-1:0] a,
                                                     input logic [1:0]           b);
        logic [ERR_CNT_W:0] s;
        s = {1'b0, a} + {{(ERR_CNT_W-1){1'b0}}, b};
        return s[ERR_CNT_W] ? {ERR_CNT_W{1'b1}} : s[ERR_CNT_W-1:0];
    endfunction

endpackage

// File: rtl/apb_reg_access_seq_timer.sv
// PREADY watchdog: counts consecutive ACCESS cycles without PREADY and flags
// expiry on the TIMEOUT_CYCLES-th such cycle. Only used when
// APB_REG_ACCESS_SEQ_TIMEOUT_EN is defined.
module apb_reg_access_seq_timer #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rstn,
    input  logic waiting,
    output logic expired
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    logic [CNT_W-1:0] wait_cnt_reg;

    // Count stalled ACCESS cycles; any other cycle restarts the count.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wait_cnt_reg <= '0;
        end else if (waiting) begin
            wait_cnt_reg <= wait_cnt_reg + 1'b1;
        end else begin
            wait_cnt_reg <= '0;
        end
    end

    assign expired = waiting && (wait_cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/apb_reg_access_seq.sv
// APB master that walks a register table: for every entry it writes WR_PAT0,
// reads back (checked against exp_rd), writes WR_PAT1, and after each transfer
// spends one bus-idle CHECK cycle comparing the live hardware value with the
// expected value for that step. Mismatches and PSLVERR accumulate in err_cnt.
// Optional feature: define APB_REG_ACCESS_SEQ_TIMEOUT_EN to abandon transfers
// whose PREADY does not arrive within TIMEOUT_CYCLES stalled cycles.
module apb_reg_access_seq
    import apb_reg_access_seq_pkg::*;
#(
    parameter int                    ADDR_WIDTH     = 64,
    parameter int                    DATA_WIDTH     = 32,
    parameter int                    ACCESS_NUM     = 5,
    parameter logic [DATA_WIDTH-1:0] WR_PAT0        = '1,
    parameter logic [DATA_WIDTH-1:0] WR_PAT1        = DATA_WIDTH'(32'h12345678),
    parameter int                    TIMEOUT_CYCLES = 255
) (
    input  logic                               clk,
    input  logic                               rstn,
    input  logic                               start,
    output logic                               busy,
    output logic                               done,
    output logic [ERR_CNT_W-1:0]               err_cnt,
    output logic                               PSEL,
    output logic                               PENABLE,
    output logic                               PWRITE,
    output logic [ADDR_WIDTH-1:0]              PADDR,
    output logic [DATA_WIDTH-1:0]              PWDATA,
    input  logic                               PREADY,
    input  logic                               PSLVERR,
    input  logic [DATA_WIDTH-1:0]              PRDATA,
    input  logic [ACCESS_NUM*ADDR_WIDTH-1:0]   acc_addr,
    input  logic [ACCESS_NUM*DATA_WIDTH-1:0]   exp_rd,
    input  logic [3*ACCESS_NUM*DATA_WIDTH-1:0] exp_hw,
    input  logic [ACCESS_NUM*DATA_WIDTH-1:0]   hw_value
);

    localparam int                IDX_W    = (ACCESS_NUM > 1) ? $clog2(ACCESS_NUM) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(ACCESS_NUM - 1);

    // Unpacked views of the flat tables.
    logic [ADDR_WIDTH-1:0] addr_tab   [ACCESS_NUM];
    logic [DATA_WIDTH-1:0] exp_rd_tab [ACCESS_NUM];
    logic [DATA_WIDTH-1:0] hw_tab     [ACCESS_NUM];
    logic [DATA_WIDTH-1:0] exp_hw_tab [ACCESS_NUM][3];

    for (genvar gi = 0; gi < ACCESS_NUM; gi++) begin : g_tab
        assign addr_tab[gi]   = acc_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
        assign exp_rd_tab[gi] = exp_rd[gi*DATA_WIDTH +: DATA_WIDTH];
        assign hw_tab[gi]     = hw_value[gi*DATA_WIDTH +: DATA_WIDTH];
        for (genvar gk = 0; gk < 3; gk++) begin : g_step
            assign exp_hw_tab[gi][gk] = exp_hw[(3*gi+gk)*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    state_e                 state_reg, state_next;
    logic [IDX_W-1:0]       idx_reg, idx_next;
    op_e                    op_reg, op_next;
    logic                   skip_reg, skip_next;
    logic [ERR_CNT_W-1:0]   err_reg, err_next;
    logic                   load;

    logic [IDX_W-1:0]       step_idx;
    op_e                    step_op;
    logic                   last_step;
    logic                   rd_bad;
    logic                   hw_bad;
    logic                   timeout;

`ifdef APB_REG_ACCESS_SEQ_TIMEOUT_EN
    apb_reg_access_seq_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .clk     (clk),
        .rstn    (rstn),
        .waiting ((state_reg == ST_ACCESS) && !PREADY),
        .expired (timeout)
    );
`else
    assign timeout = 1'b0;
`endif

    // Successor of the current (entry, op) pair in the walk order.
    always_comb begin
        step_idx  = idx_reg;
        step_op   = OP_WR0;
        last_step = 1'b0;
        case (op_reg)
            OP_WR0:  step_op = OP_RD;
            OP_RD:   step_op = OP_WR1;
            default: begin
                step_op   = OP_WR0;
                step_idx  = idx_reg + 1'b1;
                last_step = (idx_reg == LAST_IDX);
            end
        endcase
    end

    assign rd_bad = (op_reg == OP_RD) && (PRDATA != exp_rd_tab[idx_reg]);
    assign hw_bad = (hw_tab[idx_reg] != exp_hw_tab[idx_reg][op_reg]);

    // Sequencer next-state and error accounting.
    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        op_next    = op_reg;
        skip_next  = skip_reg;
        err_next   = err_reg;
        load       = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_SETUP;
                    idx_next   = '0;
                    op_next    = OP_WR0;
                    skip_next  = 1'b0;
                    err_next   = '0;
                    load       = 1'b1;
                end
            end
            ST_SETUP: begin
                state_next = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (PREADY) begin
                    state_next = ST_CHECK;
                    err_next   = sat_add(err_reg, {1'b0, rd_bad} + {1'b0, PSLVERR});
                end else if (timeout) begin
                    // Abandoned transfer: drop PSEL for one gap cycle but
                    // do not compare the hardware value for this op.
                    state_next = ST_CHECK;
                    skip_next  = 1'b1;
                    err_next   = sat_add(err_reg, 2'd1);
                end
            end
            ST_CHECK: begin
                skip_next = 1'b0;
                if (!skip_reg && hw_bad) begin
                    err_next = sat_add(err_reg, 2'd1);
                end
                if (last_step) begin
                    state_next = ST_DONE;
                end else begin
                    state_next = ST_SETUP;
                    idx_next   = step_idx;
                    op_next    = step_op;
                    load       = 1'b1;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Sequencer state registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg <= ST_IDLE;
            idx_reg   <= '0;
            op_reg    <= OP_WR0;
            skip_reg  <= 1'b0;
            err_reg   <= '0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            op_reg    <= op_next;
            skip_reg  <= skip_next;
            err_reg   <= err_next;
        end
    end

    // Address/data/direction are captured when a transfer is scheduled so
    // they hold steady from SETUP through completion.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            PADDR  <= '0;
            PWDATA <= '0;
            PWRITE <= 1'b0;
        end else if (load) begin
            PADDR  <= addr_tab[idx_next];
            PWRITE <= (op_next != OP_RD);
            case (op_next)
                OP_WR0:  PWDATA <= WR_PAT0;
                OP_WR1:  PWDATA <= WR_PAT1;
                default: PWDATA <= '0;
            endcase
        end
    end

    assign PSEL    = (state_reg == ST_SETUP) || (state_reg == ST_ACCESS);
    assign PENABLE = (state_reg == ST_ACCESS);
    assign busy    = (state_reg != ST_IDLE);
    assign done    = (state_reg == ST_DONE);
    assign err_cnt = err_reg;

endmodule
